// File: rtl/rei_pkg.sv
// rei_pkg: shared constants and types for the rei core and its trace path.
//   XLEN/ILEN    : architectural register and instruction widths
//   UNIMP        : canonical RISC-V "unimp" encoding (csrrw x0, cycle, x0)
//   commit_rec_t : one retired instruction as seen by the trace sink
//   done_cause_e : why the commit monitor declared end of simulation
package rei_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] UNIMP = 32'hc000_1073;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] ir;
      logic            rf_we;
      logic [4:0]      rd;
      logic [XLEN-1:0] rf_wdata;
   } commit_rec_t;

   typedef enum logic [1:0] {
      DONE_NONE    = 2'd0,
      DONE_UNIMP   = 2'd1,
      DONE_TIMEOUT = 2'd2,
      DONE_HANG    = 2'd3
   } done_cause_e;

endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: circular buffer accepting up to NPUSH entries per cycle and
// releasing at most one per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   push_n   : number of entries written this cycle (taken from wdata[0..])
//   wdata    : compacted write data, slot 0 is written first
//   pop      : advance the head (ignored while empty)
//   head     : entry at the read pointer (undefined while count == 0)
//   count    : registered occupancy
// The caller guarantees push_n <= DEPTH - count; no internal overflow guard.
module commit_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned NPUSH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [$clog2(NPUSH+1)-1:0]         push_n,
   input  logic [NPUSH-1:0][WIDTH-1:0]        wdata,
   input  logic                               pop,
   output logic [WIDTH-1:0]                   head,
   output logic [$clog2(DEPTH+1)-1:0]         count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap is plain modular overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_n);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count  <= count + CW'(push_n) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NPUSH; i++) begin
         if (i < 32'(push_n)) mem[wr_ptr + AW'(i)] <= wdata[i];
      end
   end

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: collects per-lane commit records from the rei commit stage,
// queues them for the trace sink and decides when simulation is over.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   max_cycles_i    : cycle timeout threshold (0 disables)
//   cm_valid_i      : per-lane commit valid, lane 0 oldest
//   cm_rec_i        : per-lane commit record
//   trace_valid_o   : FIFO head valid
//   trace_ready_i   : sink consumes the head
//   trace_rec_o     : FIFO head record (0 while empty)
//   overflow_o      : sticky, a commit group was dropped for lack of space
//   drop_cnt_o      : dropped records, saturating
//   cycle_o         : cycles since reset release, frozen once done
//   instret_o       : committed instructions, dropped ones included
//   done_o          : sticky end of simulation
//   done_cause_o    : first cause that ended the run
//   done_pc_o       : pc of the UNIMP instruction, else 0
//   drained_o       : done and trace FIFO empty
module commit_monitor
   import rei_pkg::*;
#(
   parameter int unsigned NLANE       = 2,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned HANG_CYCLES = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [63:0]                   max_cycles_i,
   input  logic [NLANE-1:0]              cm_valid_i,
   input  commit_rec_t [NLANE-1:0]       cm_rec_i,
   output logic                          trace_valid_o,
   input  logic                          trace_ready_i,
   output commit_rec_t                   trace_rec_o,
   output logic                          overflow_o,
   output logic [31:0]                   drop_cnt_o,
   output logic [63:0]                   cycle_o,
   output logic [63:0]                   instret_o,
   output logic                          done_o,
   output done_cause_e                   done_cause_o,
   output logic [XLEN-1:0]               done_pc_o,
   output logic                          drained_o
);

   localparam int unsigned NW = $clog2(NLANE+1);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned HW = $clog2(HANG_CYCLES+1);

   typedef enum logic {RUN, DONE} state_e;

   state_e                   state_q, state_d;
   done_cause_e              cause_q, cause_d;
   logic [XLEN-1:0]          pc_q, pc_d;

   commit_rec_t [NLANE-1:0]  grp;
   int unsigned              slot;
   logic [NW-1:0]            n;
   logic                     unimp_hit;
   logic [XLEN-1:0]          unimp_pc;

   logic [CW-1:0]            count;
   logic                     fits;
   logic [NW-1:0]            push_n;
   commit_rec_t              head;
   logic                     pop;

   logic [HW-1:0]            hang_q;
   logic                     timeout_hit;
   logic                     hang_hit;
   logic                     trig;
   logic [32:0]              drop_sum;

   // Compact valid lanes in lane order; an UNIMP ends the group after itself.
   // Once done, nothing is admitted, so n stays 0 and counters stay frozen.
   always_comb begin
      grp       = '0;
      slot      = 0;
      unimp_hit = 1'b0;
      unimp_pc  = '0;
      for (int unsigned i = 0; i < NLANE; i++) begin
         if (cm_valid_i[i] && !unimp_hit && (state_q == RUN)) begin
            grp[slot] = cm_rec_i[i];
            slot      = slot + 1;
            if (cm_rec_i[i].ir == UNIMP) begin
               unimp_hit = 1'b1;
               unimp_pc  = cm_rec_i[i].pc;
            end
         end
      end
      n = NW'(slot);
   end

   // Space is judged on the registered count: a same-cycle pop does not help.
   assign fits   = 32'(n) <= (DEPTH - 32'(count));
   assign push_n = fits ? n : '0;
   assign pop    = trace_valid_o && trace_ready_i;

   commit_fifo #(
      .WIDTH (($bits(commit_rec_t))),
      .DEPTH (DEPTH),
      .NPUSH (NLANE)
   ) u_fifo (
      .clk    (clk_i),
      .rst    (rst_i),
      .push_n (push_n),
      .wdata  (grp),
      .pop    (pop),
      .head   (head),
      .count  (count)
   );

   assign timeout_hit = (max_cycles_i != '0) && (cycle_o >= max_cycles_i);
   assign hang_hit    = 32'(hang_q) >= HANG_CYCLES;

   // Done FSM: first cause wins, UNIMP > TIMEOUT > HANG within a cycle.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      case (state_q)
         RUN: begin
            if (unimp_hit) begin
               state_d = DONE;
               cause_d = DONE_UNIMP;
               pc_d    = unimp_pc;
            end else if (timeout_hit) begin
               state_d = DONE;
               cause_d = DONE_TIMEOUT;
            end else if (hang_hit) begin
               state_d = DONE;
               cause_d = DONE_HANG;
            end
         end
         DONE: ;
         default: state_d = RUN;
      endcase
   end

   assign trig = (state_q == RUN) && (state_d == DONE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cause_q <= DONE_NONE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
      end
   end

   assign drop_sum = {1'b0, drop_cnt_o} + 33'(n);

   // The cycle counter skips the increment on the edge that latches done, so
   // a timeout at max_cycles_i leaves cycle_o parked on that value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_o    <= '0;
         instret_o  <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
         hang_q     <= '0;
      end else if (state_q == RUN) begin
         instret_o <= instret_o + 64'(n);
         if (!fits) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
         end
         if (!trig) cycle_o <= cycle_o + 64'd1;
         if (n != '0)         hang_q <= '0;
         else if (!hang_hit)  hang_q <= hang_q + HW'(1);
      end
   end

   assign trace_valid_o = (count != '0);
   assign trace_rec_o   = trace_valid_o ? head : '0;
   assign done_o        = (state_q == DONE);
   assign done_cause_o  = cause_q;
   assign done_pc_o     = pc_q;
   assign drained_o     = done_o && !trace_valid_o;

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed bench for commit_monitor (NLANE=2, DEPTH=8,
// HANG_CYCLES=16). A vector table covers streaming, compaction, overflow and
// drain; hand-written sequences cover UNIMP, timeout, hang and async reset.
module tb_commit_monitor;
   import rei_pkg::*;

   localparam int unsigned NL = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [63:0]         max_cycles = '0;
   logic [NL-1:0]       cm_valid = '0;
   commit_rec_t [NL-1:0] cm_rec = '0;
   logic                trace_valid;
   logic                trace_ready = 1'b0;
   commit_rec_t         trace_rec;
   logic                overflow;
   logic [31:0]         drop_cnt;
   logic [63:0]         cycle;
   logic [63:0]         instret;
   logic                done;
   done_cause_e         done_cause;
   logic [XLEN-1:0]     done_pc;
   logic                drained;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   commit_monitor #(
      .NLANE       (NL),
      .DEPTH       (8),
      .HANG_CYCLES (16)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .max_cycles_i  (max_cycles),
      .cm_valid_i    (cm_valid),
      .cm_rec_i      (cm_rec),
      .trace_valid_o (trace_valid),
      .trace_ready_i (trace_ready),
      .trace_rec_o   (trace_rec),
      .overflow_o    (overflow),
      .drop_cnt_o    (drop_cnt),
      .cycle_o       (cycle),
      .instret_o     (instret),
      .done_o        (done),
      .done_cause_o  (done_cause),
      .done_pc_o     (done_pc),
      .drained_o     (drained)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic commit_rec_t mk_rec(input logic [31:0] pc, input bit unimp);
      commit_rec_t r;
      r.pc       = pc;
      r.ir       = unimp ? UNIMP : 32'h0000_0013;
      r.rf_we    = !unimp;
      r.rd       = pc[6:2];
      r.rf_wdata = ~pc;
      return r;
   endfunction

   task automatic set_lanes(input logic [NL-1:0] v, input logic [NL-1:0] um, input logic [31:0] base);
      cm_valid = v;
      for (int i = 0; i < int'(NL); i++) cm_rec[i] = mk_rec(base + 32'(4*i), um[i]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cm_valid    = '0;
      trace_ready = 1'b0;
      max_cycles  = '0;
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid", trace_valid, 0);
      check("rst_rec", trace_rec, 0);
      check("rst_instret", instret, 0);
      check("rst_cycle", cycle, 0);
      check("rst_done", {done, done_cause, done_pc, drained}, 0);
      check("rst_ovf_drop", {overflow, drop_cnt}, 0);
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      bit          rst;
      logic [1:0]  v;
      logic        rdy;
      logic        tv;
      logic [31:0] hpc;
      logic [63:0] inst;
      logic        ovf;
      logic [31:0] drop;
   } vec_t;

   vec_t tbl [25];

   int unsigned edges;

   initial begin
      // lane pcs for row r are 0x1000 + 16*r + 4*lane
      tbl[0]  = '{1, 2'b11, 1, 1, 32'h1000,  2, 0, 0};
      tbl[1]  = '{0, 2'b11, 1, 1, 32'h1004,  4, 0, 0};
      tbl[2]  = '{0, 2'b11, 1, 1, 32'h1010,  6, 0, 0};
      tbl[3]  = '{0, 2'b10, 1, 1, 32'h1014,  7, 0, 0};
      tbl[4]  = '{0, 2'b01, 1, 1, 32'h1020,  8, 0, 0};
      tbl[5]  = '{0, 2'b00, 1, 1, 32'h1024,  8, 0, 0};
      tbl[6]  = '{0, 2'b00, 1, 1, 32'h1034,  8, 0, 0};
      tbl[7]  = '{0, 2'b00, 1, 1, 32'h1040,  8, 0, 0};
      tbl[8]  = '{0, 2'b00, 1, 0, 32'h0,     8, 0, 0};
      tbl[9]  = '{1, 2'b11, 0, 1, 32'h1090,  2, 0, 0};
      tbl[10] = '{0, 2'b11, 0, 1, 32'h1090,  4, 0, 0};
      tbl[11] = '{0, 2'b11, 0, 1, 32'h1090,  6, 0, 0};
      tbl[12] = '{0, 2'b11, 0, 1, 32'h1090,  8, 0, 0};
      tbl[13] = '{0, 2'b11, 0, 1, 32'h1090, 10, 1, 2};
      tbl[14] = '{0, 2'b11, 1, 1, 32'h1094, 12, 1, 4};
      tbl[15] = '{0, 2'b00, 1, 1, 32'h10a0, 12, 1, 4};
      tbl[16] = '{0, 2'b00, 1, 1, 32'h10a4, 12, 1, 4};
      tbl[17] = '{0, 2'b00, 1, 1, 32'h10b0, 12, 1, 4};
      tbl[18] = '{0, 2'b00, 1, 1, 32'h10b4, 12, 1, 4};
      tbl[19] = '{0, 2'b00, 1, 1, 32'h10c0, 12, 1, 4};
      tbl[20] = '{0, 2'b00, 1, 1, 32'h10c4, 12, 1, 4};
      tbl[21] = '{0, 2'b00, 1, 0, 32'h0,    12, 1, 4};
      tbl[22] = '{0, 2'b11, 1, 1, 32'h1160, 14, 1, 4};
      tbl[23] = '{0, 2'b00, 1, 1, 32'h1164, 14, 1, 4};
      tbl[24] = '{0, 2'b00, 1, 0, 32'h0,    14, 1, 4};

      for (int r = 0; r < 25; r++) begin
         if (tbl[r].rst) do_reset();
         set_lanes(tbl[r].v, 2'b00, 32'h1000 + 32'(16*r));
         trace_ready = tbl[r].rdy;
         step();
         check($sformatf("row%0d_valid", r), trace_valid, tbl[r].tv);
         check($sformatf("row%0d_rec", r), trace_rec, tbl[r].tv ? mk_rec(tbl[r].hpc, 0) : '0);
         check($sformatf("row%0d_instret", r), instret, tbl[r].inst);
         check($sformatf("row%0d_overflow", r), overflow, tbl[r].ovf);
         check($sformatf("row%0d_drop", r), drop_cnt, tbl[r].drop);
         check($sformatf("row%0d_done", r), done, 0);
      end

      // UNIMP in lane 0 with lane 1 valid: only lane 0 is kept
      do_reset();
      step();
      step();
      set_lanes(2'b11, 2'b01, 32'h2000);
      step();
      cm_valid = '0;
      check("unimp_valid", trace_valid, 1);
      check("unimp_rec", trace_rec, mk_rec(32'h2000, 1));
      check("unimp_instret", instret, 1);
      check("unimp_done", done, 1);
      check("unimp_cause", done_cause, DONE_UNIMP);
      check("unimp_pc", done_pc, 32'h2000);
      check("unimp_cycle", cycle, 2);
      check("unimp_drained0", drained, 0);
      set_lanes(2'b11, 2'b00, 32'h2010);
      step();
      cm_valid = '0;
      check("unimp_ignore_instret", instret, 1);
      check("unimp_ignore_rec", trace_rec, mk_rec(32'h2000, 1));
      check("unimp_cycle_frozen", cycle, 2);
      trace_ready = 1'b1;
      step();
      check("unimp_drain_valid", trace_valid, 0);
      check("unimp_drained1", drained, 1);

      // UNIMP in lane 1: both lanes kept, pc of lane 1 reported
      do_reset();
      set_lanes(2'b11, 2'b10, 32'h3100);
      step();
      cm_valid = '0;
      check("unimp1_instret", instret, 2);
      check("unimp1_pc", done_pc, 32'h3104);
      check("unimp1_rec", trace_rec, mk_rec(32'h3100, 0));

      // UNIMP and timeout in the same cycle: UNIMP wins
      do_reset();
      max_cycles = 64'd3;
      step();
      step();
      step();
      check("prio_notdone", done, 0);
      set_lanes(2'b01, 2'b01, 32'h3000);
      step();
      cm_valid = '0;
      check("prio_cause", done_cause, DONE_UNIMP);
      check("prio_pc", done_pc, 32'h3000);
      check("prio_cycle", cycle, 3);

      // Timeout at 20 with a single commit every cycle
      do_reset();
      max_cycles  = 64'd20;
      trace_ready = 1'b1;
      edges = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         set_lanes(2'b01, 2'b00, 32'h4000 + 32'(16*k));
         step();
         edges++;
      end
      check("tmo_edges", edges, 21);
      check("tmo_cause", done_cause, DONE_TIMEOUT);
      check("tmo_cycle", cycle, 20);
      check("tmo_instret", instret, 21);
      check("tmo_pc", done_pc, 0);
      step();
      step();
      cm_valid = '0;
      check("tmo_cycle_frozen", cycle, 20);
      check("tmo_instret_frozen", instret, 21);

      // Hang: one commit, then silence
      do_reset();
      trace_ready = 1'b1;
      set_lanes(2'b01, 2'b00, 32'h5000);
      step();
      cm_valid = '0;
      edges = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         step();
         edges++;
      end
      check("hang_edges", edges, 17);
      check("hang_cause", done_cause, DONE_HANG);
      check("hang_drained", drained, 1);
      check("hang_instret", instret, 1);

      // Async reset with 5 entries queued, no clock edge involved
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_lanes(2'b11, 2'b00, 32'h6000 + 32'(16*k));
         step();
      end
      cm_valid    = '0;
      trace_ready = 1'b1;
      step();
      check("ar_pre_valid", trace_valid, 1);
      check("ar_pre_instret", instret, 6);
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid", trace_valid, 0);
      check("ar_counters", {instret, cycle, drop_cnt}, 0);
      check("ar_done", done, 0);
      step();
      rst = 1'b0;
      set_lanes(2'b01, 2'b00, 32'h7000);
      step();
      cm_valid = '0;
      check("ar_fresh_rec", trace_rec, mk_rec(32'h7000, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
